aes_enc_arbiter: RTL and testbench

//  Shares one iterative AES-128 encryption macro (10 rounds, 1 round/clk) among NREQ requesters.

---
 rtl/aes_enc_arbiter.sv | 153 +++++++++++++++
 tb/tb_aes_enc_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_arbiter.sv
// aes_enc_arbiter: round-robin front end that shares one iterative AES-128 macro among NREQ clients.
// Define AES_ARB_KEY_CACHE_EN to skip the key-load step when the previous owner re-requests without rekey.
module aes_enc_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_data,
  input  logic [NREQ-1:0]     req_rekey,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [127:0]        rsp_data,
  output logic [127:0]        core_kin,
  output logic [127:0]        core_din,
  output logic                core_krdy,
  output logic                core_drdy,
  input  logic [127:0]        core_dout,
  input  logic                core_bsy,
  input  logic                core_dvld,
  output logic [IDW-1:0]      owner,
  output logic                busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEY_LD = 3'd1;
  localparam logic [2:0] S_DAT_ST = 3'd2;
  localparam logic [2:0] S_DAT_WT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [127:0]   kin_q, kin_d;
  logic [127:0]   din_q, din_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           key_vld_q, key_vld_d;

  logic [127:0]   key_arr [NREQ];
  logic [127:0]   dat_arr [NREQ];

  logic           hi_found, lo_found, grant_found;
  logic [IDW-1:0] hi_idx, lo_idx, grant_idx;
  logic           need_key;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign key_arr[g] = req_key[128*g +: 128];
    assign dat_arr[g] = req_data[128*g +: 128];
  end

  // Round robin: first request strictly above the last grant, else wrap to the lowest request.
  // NOTE: every variable gets a default before the loop so the block stays purely combinational.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (IDW'(i) > ptr_q) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

`ifdef AES_ARB_KEY_CACHE_EN
  assign need_key = !(key_vld_q && (grant_idx == owner_q) && !req_rekey[grant_idx]);
`else
  logic unused_cache;
  assign need_key     = 1'b1;
  assign unused_cache = ^{req_rekey, key_vld_q};
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    kin_d      = kin_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    key_vld_d  = key_vld_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          ptr_d   = grant_idx;
          owner_d = grant_idx;
          kin_d   = key_arr[grant_idx];
          din_d   = dat_arr[grant_idx];
          state_d = need_key ? S_KEY_LD : S_DAT_ST;
        end
      end
      S_KEY_LD: begin
        key_vld_d = 1'b1;
        state_d   = S_DAT_ST;
      end
      S_DAT_ST: begin
        if (!core_bsy) state_d = S_DAT_WT;
      end
      S_DAT_WT: begin
        if (core_dvld && !core_bsy) begin
          rsp_data_d = core_dout;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      owner_q    <= '0;
      kin_q      <= '0;
      din_q      <= '0;
      rsp_data_q <= '0;
      key_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      kin_q      <= kin_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      key_vld_q  <= key_vld_d;
    end
  end

  // The accept pulse is masked during reset: a grant cannot be captured while the state is held.
  assign req_ready = (state_q == S_IDLE && grant_found && !RST) ? (NREQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << owner_q) : '0;
  assign core_krdy = (state_q == S_KEY_LD);
  assign core_drdy = (state_q == S_DAT_ST) && !core_bsy;
  assign core_kin  = kin_q;
  assign core_din  = din_q;
  assign rsp_data  = rsp_data_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Testbench for aes_enc_arbiter: directed scenarios against a 10-cycle AES macro stub.
module tb_aes_enc_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req_valid, req_ready, req_rekey, rsp_valid, rsp_ready;
  logic [NREQ*128-1:0] req_key, req_data;
  logic [127:0]        rsp_data, core_kin, core_din, core_dout;
  logic                core_krdy, core_drdy, core_bsy, core_dvld, busy;
  logic [IDW-1:0]      owner;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int viol  = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  aes_enc_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
    .req_rekey(req_rekey), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_kin(core_kin), .core_din(core_din), .core_krdy(core_krdy), .core_drdy(core_drdy),
    .core_dout(core_dout), .core_bsy(core_bsy), .core_dvld(core_dvld),
    .owner(owner), .busy(busy)
  );

  // Stub cipher: the real FIPS-197 vector, otherwise a simple keyed scramble.
  function automatic logic [127:0] exp_ct(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_5a5a;
  endfunction

  function automatic logic [127:0] rr_key(input int r);
    return {32'(32'hc0de_0000 + r), 96'h1234_5678_9abc_def0_0fed_cba9};
  endfunction

  function automatic logic [127:0] rr_pt(input int r);
    return {96'hfeed_face_0bad_beef_dead_c0de, 32'(32'h0000_0100 * (r + 1))};
  endfunction

  // Macro stub: Drdy starts 10 busy cycles, then Dvld rises with the result.
  logic         stub_bsy_q, stub_dvld_q, force_bsy;
  logic [127:0] stub_key_q, stub_pt_q, stub_dout_q;
  int           stub_cnt;

  assign core_bsy  = stub_bsy_q | force_bsy;
  assign core_dvld = stub_dvld_q;
  assign core_dout = stub_dout_q;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      stub_bsy_q <= 1'b0; stub_dvld_q <= 1'b0; stub_cnt <= 0;
      stub_key_q <= '0;   stub_pt_q   <= '0;   stub_dout_q <= '0;
    end else begin
      if (core_krdy) stub_key_q <= core_kin;
      if (core_drdy) begin
        stub_bsy_q <= 1'b1; stub_dvld_q <= 1'b0; stub_cnt <= 10; stub_pt_q <= core_din;
      end else if (stub_cnt == 1) begin
        stub_cnt <= 0; stub_bsy_q <= 1'b0; stub_dvld_q <= 1'b1;
        stub_dout_q <= exp_ct(stub_key_q, stub_pt_q);
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always @(posedge CLK) begin
    if (!RST) begin
      if (core_krdy && core_drdy) viol <= viol + 1;
      if (core_drdy && core_bsy) viol <= viol + 1;
      if (core_krdy && stub_bsy_q) viol <= viol + 1;
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1; req_valid = '0; rsp_ready = '0; req_rekey = '0;
    next_cycle();
    RST = 1'b0;
    #1;
  endtask

  // One full transaction on requester idx; returns latencies relative to the accept cycle.
  task automatic run_one(input int idx, input logic [127:0] key, input logic [127:0] pt,
                         input logic rekey, output int lat_krdy, output int lat_drdy,
                         output int lat_rsp, output int n_krdy, output logic [127:0] got);
    int t0;
    lat_krdy = -1; lat_drdy = -1; lat_rsp = -1; n_krdy = 0; got = '0; t0 = -1;
    req_key[idx*128 +: 128] = key;
    req_data[idx*128 +: 128] = pt;
    req_rekey[idx] = rekey;
    req_valid[idx] = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[idx]) begin t0 = cyc; break; end
      next_cycle();
    end
    n_cmp++;
    if (t0 < 0) begin
      n_bad++; $display("FAIL accept_timeout req%0d: no req_ready within 10 cycles", idx);
      req_valid[idx] = 1'b0;
      return;
    end
    n_cmp++;
    if (req_ready !== (NREQ'(1) << idx)) begin
      n_bad++; $display("FAIL req_ready_onehot: got %b want %b", req_ready, NREQ'(1) << idx);
    end
    next_cycle();
    req_valid[idx] = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (core_krdy) begin n_krdy++; if (lat_krdy < 0) lat_krdy = cyc - t0; end
      if (core_drdy && lat_drdy < 0) lat_drdy = cyc - t0;
      if (rsp_valid[idx]) begin lat_rsp = cyc - t0; break; end
      next_cycle();
    end
    n_cmp++;
    if (lat_rsp < 0) begin
      n_bad++; $display("FAIL rsp_timeout req%0d: no rsp_valid within 40 cycles", idx);
      return;
    end
    got = rsp_data;
    n_cmp++;
    if (rsp_valid !== (NREQ'(1) << idx)) begin
      n_bad++; $display("FAIL rsp_valid_onehot: got %b want %b", rsp_valid, NREQ'(1) << idx);
    end
    rsp_ready[idx] = 1'b1;
    next_cycle();
    rsp_ready[idx] = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      n_bad++; $display("FAIL idle_after_rsp: busy %b rsp_valid %b want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++;
    if (rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    if ({rsp_data, core_kin, core_din} !== '0) begin
      n_bad++; $display("FAIL reset_data_regs: rsp %h kin %h din %h want 0", rsp_data, core_kin, core_din);
    end
    n_cmp++;
    if ({core_krdy, core_drdy, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes: krdy/drdy/busy %b want 000", {core_krdy, core_drdy, busy});
    end
    n_cmp++;
    if (owner !== '0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
    req_valid = '0;
    RST = 1'b0;
    #1;
  endtask

  task automatic test_fips();
    int lk, ld, lr, nk;
    logic [127:0] got;
    run_one(0, FIPS_KEY, FIPS_PT, 1'b0, lk, ld, lr, nk, got);
    n_cmp++;
    if (got !== FIPS_CT) begin n_bad++; $display("FAIL fips_ct: got %h want %h", got, FIPS_CT); end
    n_cmp++;
    if (lr !== 14) begin n_bad++; $display("FAIL fips_rsp_latency: got %0d want 14", lr); end
    n_cmp++;
    if (lk !== 1 || ld !== 2) begin
      n_bad++; $display("FAIL fips_strobe_latency: krdy %0d drdy %0d want 1/2", lk, ld);
    end
    n_cmp++;
    if (nk !== 1) begin n_bad++; $display("FAIL fips_krdy_count: got %0d want 1", nk); end
  endtask

  task automatic test_round_robin();
    int g_idx[5];
    int g_cyc[5];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int g_cnt;
    int last;
    apply_reset();
    for (int r = 0; r < NREQ; r++) begin
      req_key[r*128 +: 128] = rr_key(r);
      req_data[r*128 +: 128] = rr_pt(r);
    end
    rsp_ready = '1;
    req_valid = '1;
    #1;
    g_cnt = 0;
    for (int i = 0; i < 120 && g_cnt < 5; i++) begin
      if (req_ready !== '0) begin
        n_cmp++;
        if (!$onehot(req_ready)) begin n_bad++; $display("FAIL rr_onehot: req_ready %b", req_ready); end
        for (int r = 0; r < NREQ; r++) if (req_ready[r]) g_idx[g_cnt] = r;
        g_cyc[g_cnt] = cyc;
        g_cnt++;
      end else if (rsp_valid !== '0 && g_cnt > 0) begin
        last = g_idx[g_cnt-1];
        n_cmp++;
        if (rsp_valid !== (NREQ'(1) << last) || rsp_data !== exp_ct(rr_key(last), rr_pt(last))) begin
          n_bad++; $display("FAIL rr_rsp: valid %b data %h want req%0d data %h",
                            rsp_valid, rsp_data, last, exp_ct(rr_key(last), rr_pt(last)));
        end
      end
      if (g_cnt < 5) next_cycle();
    end
    n_cmp++;
    if (g_cnt != 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 5", g_cnt); end
    for (int k = 0; k < g_cnt; k++) begin
      n_cmp++;
      if (g_idx[k] != exp_seq[k]) begin
        n_bad++; $display("FAIL rr_order[%0d]: got req%0d want req%0d", k, g_idx[k], exp_seq[k]);
      end
      if (k > 0) begin
        n_cmp++;
        if (g_cyc[k] - g_cyc[k-1] != 15) begin
          n_bad++; $display("FAIL rr_spacing[%0d]: got %0d want 15", k, g_cyc[k] - g_cyc[k-1]);
        end
      end
    end
    next_cycle();
    req_valid = '0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid !== '0) break;
      next_cycle();
    end
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_data !== exp_ct(rr_key(0), rr_pt(0))) begin
      n_bad++; $display("FAIL rr_last_rsp: valid %b data %h want 0001 %h",
                        rsp_valid, rsp_data, exp_ct(rr_key(0), rr_pt(0)));
    end
    next_cycle();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_drain_idle: busy %b want 0", busy); end
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [127:0] k1, d1, k3, d3;
    int t0;
    k1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    k3 = 128'h3333_0000_3333_0000_3333_0000_3333_0000;
    d3 = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
    req_key[1*128 +: 128] = k1; req_data[1*128 +: 128] = d1;
    req_key[3*128 +: 128] = k3; req_data[3*128 +: 128] = d3;
    req_rekey = '0;
    req_valid[1] = 1'b1;
    #1;
    t0 = -1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[1]) begin t0 = cyc; break; end
      next_cycle();
    end
    n_cmp++;
    if (t0 < 0) begin n_bad++; $display("FAIL bp_accept_timeout: no req_ready[1]"); end
    next_cycle();
    req_valid[1] = 1'b0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid[1]) break;
      next_cycle();
    end
    req_valid[3] = 1'b1;
    rsp_ready = 4'b1101;
    #1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (rsp_valid !== 4'b0010 || rsp_data !== exp_ct(k1, d1)) begin
        n_bad++; $display("FAIL bp_hold[%0d]: valid %b data %h want 0010 %h", i, rsp_valid, rsp_data, exp_ct(k1, d1));
      end
      n_cmp++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL bp_no_accept[%0d]: req_ready %b busy %b want 0000/1", i, req_ready, busy);
      end
      next_cycle();
    end
    rsp_ready = 4'b0010;
    next_cycle();
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL bp_release: busy %b rsp_valid %b req_ready %b want 0/0000/1000", busy, rsp_valid, req_ready);
    end
    next_cycle();
    req_valid[3] = 1'b0;
    rsp_ready = '0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid[3]) break;
      next_cycle();
    end
    n_cmp++;
    if (rsp_valid !== 4'b1000 || rsp_data !== exp_ct(k3, d3)) begin
      n_bad++; $display("FAIL bp_req3_rsp: valid %b data %h want 1000 %h", rsp_valid, rsp_data, exp_ct(k3, d3));
    end
    rsp_ready[3] = 1'b1;
    next_cycle();
    rsp_ready = '0;
    #1;
  endtask

  task automatic test_key_cache();
    int lk, ld, lr, nk;
    logic [127:0] got, k2;
    k2 = 128'h2222_aaaa_2222_bbbb_2222_cccc_2222_dddd;
    run_one(2, k2, 128'h0000_0000_0000_0000_0000_0000_0000_0001, 1'b0, lk, ld, lr, nk, got);
    n_cmp++;
    if (nk !== 1 || lr !== 14 || got !== exp_ct(k2, 128'h1)) begin
      n_bad++; $display("FAIL cache_first: krdy %0d lat %0d data %h want 1/14/%h", nk, lr, got, exp_ct(k2, 128'h1));
    end
    run_one(2, k2, 128'h0000_0000_0000_0000_0000_0000_0000_0002, 1'b0, lk, ld, lr, nk, got);
`ifdef AES_ARB_KEY_CACHE_EN
    n_cmp++;
    if (nk !== 0 || ld !== 1 || lr !== 13) begin
      n_bad++; $display("FAIL cache_hit: krdy %0d drdy_lat %0d rsp_lat %0d want 0/1/13", nk, ld, lr);
    end
`else
    n_cmp++;
    if (nk !== 1 || ld !== 2 || lr !== 14) begin
      n_bad++; $display("FAIL cache_off_second: krdy %0d drdy_lat %0d rsp_lat %0d want 1/2/14", nk, ld, lr);
    end
`endif
    n_cmp++;
    if (got !== exp_ct(k2, 128'h2)) begin
      n_bad++; $display("FAIL cache_second_data: got %h want %h", got, exp_ct(k2, 128'h2));
    end
    run_one(2, k2, 128'h0000_0000_0000_0000_0000_0000_0000_0003, 1'b1, lk, ld, lr, nk, got);
    n_cmp++;
    if (nk !== 1 || lk !== 1 || lr !== 14 || got !== exp_ct(k2, 128'h3)) begin
      n_bad++; $display("FAIL cache_rekey: krdy %0d/%0d lat %0d data %h want 1/1/14/%h", nk, lk, lr, got, exp_ct(k2, 128'h3));
    end
    req_rekey = '0;
  endtask

  task automatic test_reset_mid_op();
    int lk, ld, lr, nk;
    logic [127:0] got;
    req_key[1*128 +: 128] = 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100;
    req_data[1*128 +: 128] = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    req_valid[1] = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[1]) break;
      next_cycle();
    end
    next_cycle();
    req_valid[1] = 1'b0;
    repeat (5) next_cycle();
    n_cmp++;
    if (busy !== 1'b1 || owner !== 2'd1) begin
      n_bad++; $display("FAIL rst_mid_precheck: busy %b owner %0d want 1/1", busy, owner);
    end
    req_valid[2] = 1'b1;
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, core_krdy, core_drdy, busy} !== '0 || owner !== '0) begin
      n_bad++; $display("FAIL rst_mid_ctrl: req_ready %b rsp_valid %b krdy %b drdy %b busy %b owner %0d want all 0",
                        req_ready, rsp_valid, core_krdy, core_drdy, busy, owner);
    end
    n_cmp++;
    if ({rsp_data, core_kin, core_din} !== '0) begin
      n_bad++; $display("FAIL rst_mid_data: rsp %h kin %h din %h want 0", rsp_data, core_kin, core_din);
    end
    next_cycle();
    n_cmp++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_hold: req_ready %b busy %b want 0/0", req_ready, busy);
    end
    req_valid = '0;
    RST = 1'b0;
    next_cycle();
    run_one(0, FIPS_KEY, FIPS_PT, 1'b0, lk, ld, lr, nk, got);
    n_cmp++;
    if (got !== FIPS_CT || lr !== 14 || nk !== 1) begin
      n_bad++; $display("FAIL rst_mid_fresh: data %h lat %0d krdy %0d want %h/14/1", got, lr, nk, FIPS_CT);
    end
  endtask

  task automatic test_bsy_hold();
    logic [127:0] kb, db;
    int d0;
    kb = 128'hbbbb_0000_1111_2222_3333_4444_5555_6666;
    db = 128'h6666_5555_4444_3333_2222_1111_0000_bbbb;
    req_key[2*128 +: 128] = kb; req_data[2*128 +: 128] = db;
    req_rekey[2] = 1'b1;
    req_valid[2] = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[2]) break;
      next_cycle();
    end
    next_cycle();
    req_valid[2] = 1'b0;
    req_rekey[2] = 1'b0;
    #1;
    n_cmp++;
    if (core_krdy !== 1'b1) begin n_bad++; $display("FAIL bsy_krdy: got %b want 1", core_krdy); end
    force_bsy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      n_cmp++;
      if (core_drdy !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL bsy_hold[%0d]: drdy %b busy %b want 0/1", i, core_drdy, busy);
      end
    end
    force_bsy = 1'b0;
    #1;
    n_cmp++;
    if (core_drdy !== 1'b1) begin n_bad++; $display("FAIL bsy_release_drdy: got %b want 1", core_drdy); end
    d0 = cyc;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid[2]) break;
      next_cycle();
    end
    n_cmp++;
    if (rsp_valid !== 4'b0100 || cyc - d0 != 12 || rsp_data !== exp_ct(kb, db)) begin
      n_bad++; $display("FAIL bsy_rsp: valid %b lat %0d data %h want 0100/12/%h", rsp_valid, cyc - d0, rsp_data, exp_ct(kb, db));
    end
    rsp_ready[2] = 1'b1;
    next_cycle();
    rsp_ready = '0;
    #1;
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL strobe_protocol: %0d violations want 0", viol); end
  endtask

  initial begin
    RST = 1'b1; force_bsy = 1'b0;
    req_valid = '0; req_rekey = '0; rsp_ready = '0; req_key = '0; req_data = '0;
    test_reset();
    test_fips();
    test_round_robin();
    test_backpressure();
    test_key_cache();
    test_reset_mid_op();
    test_bsy_hold();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
